// File: rtl/mvu_core_share_arbiter.sv
// Shares one MVU/VVU compute core between two requesters, round-robin at block granularity.
// A tag FIFO records block ownership in issue order and steers each core result to its owner.
module mvu_core_share_arbiter #(
    parameter int D_BITS    = 16,
    parameter int P_BITS    = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk2x,
    input  logic              rst,

    input  logic [D_BITS-1:0] s0_tdata,
    input  logic              s0_tlast,
    input  logic              s0_tvalid,
    output logic              s0_tready,

    input  logic [D_BITS-1:0] s1_tdata,
    input  logic              s1_tlast,
    input  logic              s1_tvalid,
    output logic              s1_tready,

    output logic              core_en,
    output logic              core_last,
    output logic              core_zero,
    output logic [D_BITS-1:0] core_dat,
    input  logic              core_vld,
    input  logic [P_BITS-1:0] core_p,

    output logic [P_BITS-1:0] m0_tdata,
    output logic              m0_tvalid,
    input  logic              m0_tready,

    output logic [P_BITS-1:0] m1_tdata,
    output logic              m1_tvalid,
    input  logic              m1_tready,

    output logic              err
);

    localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(TAG_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    logic [1:0]           r_state;
    logic                 r_rr;
    logic [TAG_DEPTH-1:0] r_tag;
    logic [AW-1:0]        r_wp;
    logic [AW-1:0]        r_rp;
    logic [AW:0]          r_cnt;
    logic [P_BITS-1:0]    r_out0;
    logic [P_BITS-1:0]    r_out1;
    logic                 r_ov0;
    logic                 r_ov1;
    logic                 r_err;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_head;
    logic                 w_head_vld;
    logic                 w_gv;
    logic                 w_g;
    logic                 w_sg_valid;
    logic                 w_sg_last;
    logic [D_BITS-1:0]    w_sg_data;
    logic                 w_sg_ready;
    logic                 w_acc;
    logic                 w_push;
    logic                 w_pop;

    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == FULL_CNT);
    assign w_head     = r_tag[r_rp];
    assign w_head_vld = w_head ? r_ov1 : r_ov0;

    // Stall only when a real result would overwrite a result still waiting for its consumer.
    assign core_en = !(core_vld && !w_empty && w_head_vld);

    always_comb begin
        w_gv = 1'b0;
        w_g  = 1'b0;
        case (r_state)
            LOCK0: begin
                w_gv = 1'b1;
                w_g  = 1'b0;
            end
            LOCK1: begin
                w_gv = 1'b1;
                w_g  = 1'b1;
            end
            default: begin
                if (s0_tvalid && s1_tvalid) begin
                    w_gv = 1'b1;
                    w_g  = r_rr;
                end else if (s0_tvalid) begin
                    w_gv = 1'b1;
                    w_g  = 1'b0;
                end else if (s1_tvalid) begin
                    w_gv = 1'b1;
                    w_g  = 1'b1;
                end
            end
        endcase
    end

    assign w_sg_valid = w_g ? s1_tvalid : s0_tvalid;
    assign w_sg_last  = w_g ? s1_tlast  : s0_tlast;
    assign w_sg_data  = w_g ? s1_tdata  : s0_tdata;

    assign w_sg_ready = w_gv && core_en && (!w_sg_last || !w_full);
    assign s0_tready  = w_sg_ready && !w_g;
    assign s1_tready  = w_sg_ready && w_g;

    assign w_acc     = w_sg_valid && w_sg_ready;
    assign core_dat  = w_sg_data;
    assign core_zero = !w_acc;
    assign core_last = w_acc && w_sg_last;

    assign w_push = w_acc && w_sg_last;
    assign w_pop  = core_vld && core_en && !w_empty;

    always_ff @(posedge clk2x) begin
        if (rst) begin
            r_state <= IDLE;
            r_rr    <= 1'b0;
        end else if (w_acc) begin
            if (w_sg_last) begin
                r_state <= IDLE;
                r_rr    <= !w_g;
            end else begin
                r_state <= w_g ? LOCK1 : LOCK0;
            end
        end
    end

    always_ff @(posedge clk2x) begin
        if (rst) begin
            r_tag <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_tag[r_wp] <= w_g;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk2x) begin
        if (rst) begin
            r_out0 <= '0;
            r_out1 <= '0;
            r_ov0  <= 1'b0;
            r_ov1  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            // A reload wins over the consumer's handshake in the same cycle.
            if (w_pop && !w_head) begin
                r_out0 <= core_p;
                r_ov0  <= 1'b1;
            end else if (m0_tready) begin
                r_ov0  <= 1'b0;
            end
            if (w_pop && w_head) begin
                r_out1 <= core_p;
                r_ov1  <= 1'b1;
            end else if (m1_tready) begin
                r_ov1  <= 1'b0;
            end
            if (core_vld && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign m0_tdata  = r_out0;
    assign m0_tvalid = r_ov0;
    assign m1_tdata  = r_out1;
    assign m1_tvalid = r_ov1;
    assign err       = r_err;

endmodule

// File: tb/tb_mvu_core_share_arbiter.sv
// Directed bench for mvu_core_share_arbiter with an in-order accumulate-and-delay core model.
module tb_mvu_core_share_arbiter;

    localparam int DB = 8;
    localparam int PB = 16;
    localparam int TD = 2;

    logic          clk2x = 1'b0;
    logic          rst;
    logic [DB-1:0] s0_tdata, s1_tdata;
    logic          s0_tlast, s0_tvalid, s0_tready;
    logic          s1_tlast, s1_tvalid, s1_tready;
    logic          core_en, core_last, core_zero;
    logic [DB-1:0] core_dat;
    logic          core_vld;
    logic [PB-1:0] core_p;
    logic [PB-1:0] m0_tdata, m1_tdata;
    logic          m0_tvalid, m0_tready, m1_tvalid, m1_tready;
    logic          err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk2x = ~clk2x;

    mvu_core_share_arbiter #(.D_BITS(DB), .P_BITS(PB), .TAG_DEPTH(TD)) dut (
        .clk2x(clk2x), .rst(rst),
        .s0_tdata(s0_tdata), .s0_tlast(s0_tlast), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tlast(s1_tlast), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .core_en(core_en), .core_last(core_last), .core_zero(core_zero), .core_dat(core_dat),
        .core_vld(core_vld), .core_p(core_p),
        .m0_tdata(m0_tdata), .m0_tvalid(m0_tvalid), .m0_tready(m0_tready),
        .m1_tdata(m1_tdata), .m1_tvalid(m1_tvalid), .m1_tready(m1_tready),
        .err(err)
    );

    // Core model: sums the beats of a block, returns the sum lat cycles after the last beat.
    typedef struct {
        logic [PB-1:0] v;
        int            due;
    } res_t;

    res_t          q[$];
    res_t          r_tmp;
    int            cyc       = 0;
    int            lat       = 1;
    logic          hold      = 1'b0;
    logic          force_vld = 1'b0;
    logic          m_vld     = 1'b0;
    logic [PB-1:0] m_p       = '0;
    logic [PB-1:0] acc_m     = '0;
    logic [PB-1:0] rx0[$];
    logic [PB-1:0] rx1[$];

    assign core_vld = m_vld | force_vld;
    assign core_p   = m_p;

    always @(posedge clk2x) begin
        if (rst) begin
            q.delete();
            acc_m = '0;
            m_vld <= 1'b0;
        end else begin
            if (m_vld && core_en) r_tmp = q.pop_front();
            if (core_en && !core_zero) begin
                acc_m = acc_m + PB'(core_dat);
                if (core_last) begin
                    q.push_back('{acc_m, cyc + lat});
                    acc_m = '0;
                end
            end
            cyc++;
            if (q.size() > 0 && q[0].due <= cyc && !hold) begin
                m_vld <= 1'b1;
                m_p   <= q[0].v;
            end else begin
                m_vld <= 1'b0;
            end
        end
    end

    always @(posedge clk2x) begin
        if (!rst) begin
            if (m0_tvalid && m0_tready) rx0.push_back(m0_tdata);
            if (m1_tvalid && m1_tready) rx1.push_back(m1_tdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        s0_tlast = 1'b0;
        s1_tlast = 1'b0;
        force_vld = 1'b0;
        hold = 1'b0;
        repeat (2) @(posedge clk2x);
        #1 rst = 1'b0;
        rx0.delete();
        rx1.delete();
    endtask

    task automatic beat(input int who, input logic [DB-1:0] d, input logic l, output logic saw_last);
        int   n = 0;
        logic rdy;
        if (who == 0) begin
            s0_tdata = d; s0_tlast = l; s0_tvalid = 1'b1;
        end else begin
            s1_tdata = d; s1_tlast = l; s1_tvalid = 1'b1;
        end
        @(negedge clk2x);
        rdy = (who == 0) ? s0_tready : s1_tready;
        while (!rdy && n < 50) begin
            n++;
            @(negedge clk2x);
            rdy = (who == 0) ? s0_tready : s1_tready;
        end
        if (!rdy) check_eq("beat_timeout", rdy, 1);
        saw_last = core_last;
        @(posedge clk2x);
        #1;
        if (who == 0) s0_tvalid = 1'b0;
        else          s1_tvalid = 1'b0;
    endtask

    task automatic check_rx(input string tag, input int idx, input int which, input logic [PB-1:0] exp);
        logic [PB-1:0] v;
        v = 'hdead;
        if (which == 0 && idx < rx0.size()) v = rx0[idx];
        if (which == 1 && idx < rx1.size()) v = rx1[idx];
        check_eq(tag, v, exp);
    endtask

    initial begin
        logic          sl;
        int            i0, i1, ex;
        logic [PB-1:0] t1_exp[3];
        t1_exp[0] = 16'd10;
        t1_exp[1] = 16'd74;
        t1_exp[2] = 16'd138;
        s0_tdata = '0;
        s1_tdata = '0;
        m0_tready = 1'b1;
        m1_tready = 1'b1;
        do_reset();

        // Reset state
        @(negedge clk2x);
        check_eq("rst_m0_tvalid", m0_tvalid, 0);
        check_eq("rst_m1_tvalid", m1_tvalid, 0);
        check_eq("rst_core_zero", core_zero, 1);
        check_eq("rst_core_last", core_last, 0);
        check_eq("rst_core_en", core_en, 1);
        check_eq("rst_s0_tready", s0_tready, 0);
        check_eq("rst_err", err, 0);
        @(posedge clk2x); #1;

        // Single requester: 3 blocks of 4 beats, latency 5
        lat = 5;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++) begin
                beat(0, DB'(b*16 + k + 1), k == 3, sl);
                check_eq($sformatf("t1_last_b%0d_k%0d", b, k), sl, 32'(k == 3));
            end
        end
        repeat (20) @(posedge clk2x); #1;
        check_eq("t1_rx0_count", rx0.size(), 3);
        check_eq("t1_rx1_count", rx1.size(), 0);
        for (int i = 0; i < 3; i++) check_rx($sformatf("t1_rx0_%0d", i), i, 0, t1_exp[i]);

        // Contention: both continuously valid, 2-beat blocks
        do_reset();
        lat = 1;
        i0 = 0; i1 = 0;
        s0_tdata = 8'h01; s0_tlast = 1'b0; s0_tvalid = 1'b1;
        s1_tdata = 8'h11; s1_tlast = 1'b0; s1_tvalid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            ex = (c / 2) % 2;
            @(negedge clk2x);
            check_eq($sformatf("t2_s0_rdy_%0d", c), s0_tready, 32'(ex == 0));
            check_eq($sformatf("t2_s1_rdy_%0d", c), s1_tready, 32'(ex == 1));
            check_eq($sformatf("t2_zero_%0d", c), core_zero, 0);
            check_eq($sformatf("t2_last_%0d", c), core_last, 32'(c % 2));
            @(posedge clk2x); #1;
            if (ex == 0) begin
                i0++; s0_tdata = DB'(8'h01 + i0); s0_tlast = (i0 % 2) == 1;
            end else begin
                i1++; s1_tdata = DB'(8'h11 + i1); s1_tlast = (i1 % 2) == 1;
            end
        end
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        repeat (10) @(posedge clk2x); #1;
        check_eq("t2_rx0_count", rx0.size(), 2);
        check_eq("t2_rx1_count", rx1.size(), 2);
        check_rx("t2_rx0_0", 0, 0, 16'h0003);
        check_rx("t2_rx0_1", 1, 0, 16'h0007);
        check_rx("t2_rx1_0", 0, 1, 16'h0023);
        check_rx("t2_rx1_1", 1, 1, 16'h0027);

        // Lock hold: s1 arrives mid s0 block
        do_reset();
        s0_tdata = 8'h21; s0_tlast = 1'b0; s0_tvalid = 1'b1;
        @(negedge clk2x);
        check_eq("t3_s0_first", s0_tready, 1);
        @(posedge clk2x); #1;
        s1_tdata = 8'h50; s1_tlast = 1'b1; s1_tvalid = 1'b1;
        s0_tdata = 8'h22;
        @(negedge clk2x);
        check_eq("t3_s1_blocked_a", s1_tready, 0);
        check_eq("t3_s0_mid", s0_tready, 1);
        @(posedge clk2x); #1;
        s0_tdata = 8'h23; s0_tlast = 1'b1;
        @(negedge clk2x);
        check_eq("t3_s1_blocked_b", s1_tready, 0);
        check_eq("t3_s0_last", core_last, 1);
        @(posedge clk2x); #1;
        s0_tvalid = 1'b0;
        @(negedge clk2x);
        check_eq("t3_s1_granted", s1_tready, 1);
        @(posedge clk2x); #1;
        s1_tvalid = 1'b0;
        repeat (6) @(posedge clk2x); #1;
        check_rx("t3_rx0", 0, 0, 16'h0066);
        check_rx("t3_rx1", 0, 1, 16'h0050);

        // Tag full with results held off
        do_reset();
        hold = 1'b1;
        beat(0, 8'h01, 1'b1, sl);
        beat(0, 8'h02, 1'b1, sl);
        s0_tdata = 8'h03; s0_tlast = 1'b1; s0_tvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk2x);
            check_eq($sformatf("t4_full_rdy_%0d", c), s0_tready, 0);
        end
        @(posedge clk2x); #1;
        hold = 1'b0;
        beat(0, 8'h03, 1'b1, sl);
        check_eq("t4_third_last", sl, 1);
        repeat (8) @(posedge clk2x); #1;
        check_eq("t4_rx0_count", rx0.size(), 3);
        check_rx("t4_rx0_0", 0, 0, 16'h0001);
        check_rx("t4_rx0_1", 1, 0, 16'h0002);
        check_rx("t4_rx0_2", 2, 0, 16'h0003);

        // Backpressure on m1 stalls the core
        do_reset();
        m1_tready = 1'b0;
        beat(1, 8'h40, 1'b1, sl);
        beat(1, 8'h41, 1'b1, sl);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk2x);
            check_eq($sformatf("t5_stall_%0d", c), core_en, 0);
            check_eq($sformatf("t5_m1_vld_%0d", c), m1_tvalid, 1);
            check_eq($sformatf("t5_m1_dat_%0d", c), m1_tdata, 16'h0040);
            @(posedge clk2x); #1;
        end
        m1_tready = 1'b1;
        repeat (5) @(posedge clk2x); #1;
        check_eq("t5_core_en_back", core_en, 1);
        check_eq("t5_rx1_count", rx1.size(), 2);
        check_rx("t5_rx1_0", 0, 1, 16'h0040);
        check_rx("t5_rx1_1", 1, 1, 16'h0041);
        check_eq("t5_rx0_count", rx0.size(), 0);

        // Error on empty FIFO, then reset mid-block
        do_reset();
        @(posedge clk2x); #1;
        force_vld = 1'b1;
        @(posedge clk2x); #1;
        force_vld = 1'b0;
        @(negedge clk2x);
        check_eq("t6_err_set", err, 1);
        check_eq("t6_m0_discard", m0_tvalid, 0);
        check_eq("t6_m1_discard", m1_tvalid, 0);
        repeat (3) @(posedge clk2x); #1;
        check_eq("t6_err_sticky", err, 1);
        beat(0, 8'h07, 1'b1, sl);
        s1_tdata = 8'h08; s1_tlast = 1'b0; s1_tvalid = 1'b1;
        @(negedge clk2x);
        check_eq("t6_s1_granted", s1_tready, 1);
        @(posedge clk2x); #1;
        rst = 1'b1;
        s0_tdata = 8'h09; s0_tlast = 1'b1; s0_tvalid = 1'b1;
        @(posedge clk2x); #1;
        rst = 1'b0;
        @(negedge clk2x);
        check_eq("t6_rst_err", err, 0);
        check_eq("t6_rst_m0_vld", m0_tvalid, 0);
        check_eq("t6_rst_m1_vld", m1_tvalid, 0);
        check_eq("t6_rst_s0_rdy", s0_tready, 1);
        check_eq("t6_rst_s1_rdy", s1_tready, 0);
        @(posedge clk2x); #1;
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        repeat (3) @(posedge clk2x);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
